axis_packetizer: RTL and testbench



---
 rtl/axis_pkt_pkg.sv | 26 ++
 rtl/axis_packetizer_if.sv | 15 +
 rtl/axis_pkt_buf.sv | 23 ++
 rtl/axis_packetizer.sv | 144 ++++++++++++++
 tb/tb_axis_packetizer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types, defaults and the width helper for the axis_packetizer slice.
// Optional build macro used by this slice: AXIS_PKT_PAD_EN.
package axis_pkt_pkg;

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int DEF_PKT_WORDS      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   // Bits needed to index 'value' distinct items: ceil(log2(value)).
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_packetizer_if.sv
// AXI-Stream bundle with master/slave views for the packetizer's input and output.
// A beat transfers on a rising edge where tvalid && tready; once tvalid is high the
// master holds tdata/tlast stable and keeps tvalid high until that edge.
interface axis_packetizer_if #(
   parameter int DATA_W = 32
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tstrb;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_buf.sv
// Packet storage: one synchronous write port, asynchronous read. Contents are not reset.
module axis_pkt_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axis_packetizer.sv
// Store-and-forward framer: fills up to PKT_WORDS words, then emits them as one TLAST packet.
// Build macro AXIS_PKT_PAD_EN pads timeout / early-TLAST packets with zeros to PKT_WORDS beats.
module axis_packetizer
   import axis_pkt_pkg::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int PKT_WORDS            = DEF_PKT_WORDS,
   parameter int TIMEOUT_CYCLES       = DEF_TIMEOUT_CYCLES
) (
   input  logic                AXIS_ACLK,
   input  logic                AXIS_ARESETN,
   axis_packetizer_if.slave    s_axis,
   axis_packetizer_if.master   m_axis,
   output logic [15:0]         pkt_count,
   output logic                short_pkt,
   output state_t              o_dbg_state
);
   localparam int PW = clogb2(PKT_WORDS + 1);
   localparam int IW = clogb2(PKT_WORDS);
   localparam int TW = (clogb2(TIMEOUT_CYCLES) < 1) ? 1 : clogb2(TIMEOUT_CYCLES);
   localparam logic [PW-1:0] P_ONE    = PW'(1);
   localparam logic [PW-1:0] LAST_IDX = PW'(PKT_WORDS - 1);
   localparam logic [PW-1:0] FULL_LEN = PW'(PKT_WORDS);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                    r_state, w_state_nxt;
   logic [PW-1:0]             r_wr_ptr, w_wr_ptr_nxt;
   logic [PW-1:0]             r_rd_ptr, w_rd_ptr_nxt;
   logic [PW-1:0]             r_len, w_len_nxt;
   logic [TW-1:0]             r_timer, w_timer_nxt;
   logic [15:0]               r_pkt_count, w_pkt_count_nxt;
   logic                      r_short, w_short_nxt;
   logic                      r_en;
   logic                      w_accept, w_out_hs, w_last_beat;
   logic [PW-1:0]             w_send_len;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] w_rdata;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] w_out_data;
   logic                      w_unused_strb;

   // r_len always holds the real word count; padding only stretches the emitted length.
`ifdef AXIS_PKT_PAD_EN
   assign w_send_len = FULL_LEN;
   assign w_out_data = (r_rd_ptr < r_len) ? w_rdata : '0;
`else
   assign w_send_len = r_len;
   assign w_out_data = w_rdata;
`endif

   assign w_unused_strb   = ^s_axis.tstrb;
   assign s_axis.tready   = r_en && (r_state == FILL);
   assign m_axis.tvalid   = (r_state == SEND);
   assign w_last_beat     = (r_rd_ptr == (w_send_len - P_ONE));
   assign m_axis.tlast    = (r_state == SEND) && w_last_beat;
   assign m_axis.tdata    = (r_state == SEND) ? w_out_data : '0;
   assign m_axis.tstrb    = '1;
   assign w_accept        = s_axis.tvalid && s_axis.tready;
   assign w_out_hs        = m_axis.tvalid && m_axis.tready;
   assign pkt_count       = r_pkt_count;
   assign short_pkt       = r_short;
   assign o_dbg_state     = r_state;

   axis_pkt_buf #(
      .DATA_W (C_S_AXIS_TDATA_WIDTH),
      .DEPTH  (PKT_WORDS),
      .AW     (IW)
   ) u_buf (
      .i_clk   (AXIS_ACLK),
      .i_we    (w_accept),
      .i_waddr (r_wr_ptr[IW-1:0]),
      .i_wdata (s_axis.tdata),
      .i_raddr (r_rd_ptr[IW-1:0]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         r_state     <= FILL;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_len       <= '0;
         r_timer     <= '0;
         r_pkt_count <= '0;
         r_short     <= 1'b0;
         r_en        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_len       <= w_len_nxt;
         r_timer     <= w_timer_nxt;
         r_pkt_count <= w_pkt_count_nxt;
         r_short     <= w_short_nxt;
         r_en        <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_wr_ptr_nxt    = r_wr_ptr;
      w_rd_ptr_nxt    = r_rd_ptr;
      w_len_nxt       = r_len;
      w_timer_nxt     = r_timer;
      w_pkt_count_nxt = r_pkt_count;
      w_short_nxt     = 1'b0;
      case (r_state)
         FILL: begin
            // An accept on the expiry cycle wins: the beat is kept and the idle timer restarts.
            if (w_accept) begin
               w_timer_nxt = '0;
               if ((r_wr_ptr == LAST_IDX) || s_axis.tlast) begin
                  w_len_nxt   = r_wr_ptr + P_ONE;
                  w_state_nxt = SEND;
               end else begin
                  w_wr_ptr_nxt = r_wr_ptr + P_ONE;
               end
            end else if (r_wr_ptr != '0) begin
               if (r_timer == TMO_LAST) begin
                  w_len_nxt   = r_wr_ptr;
                  w_state_nxt = SEND;
               end else begin
                  w_timer_nxt = r_timer + T_ONE;
               end
            end
         end
         SEND: begin
            if (w_out_hs) begin
               if (w_last_beat) begin
                  w_rd_ptr_nxt    = '0;
                  w_wr_ptr_nxt    = '0;
                  w_timer_nxt     = '0;
                  w_pkt_count_nxt = r_pkt_count + 16'd1;
                  w_short_nxt     = (r_len != FULL_LEN);
                  w_state_nxt     = FILL;
               end else begin
                  w_rd_ptr_nxt = r_rd_ptr + P_ONE;
               end
            end
         end
         default: w_state_nxt = FILL;
      endcase
   end
endmodule

// File: tb/tb_axis_packetizer.sv
// Randomized scoreboard bench for axis_packetizer; the model frames packets from word lists.
// Build with AXIS_PKT_PAD_EN defined to check the zero-padded packet form.
module tb_axis_packetizer;
   import axis_pkt_pkg::*;

   localparam int W   = 32;
   localparam int PKT = 8;
   localparam int TMO = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pkt_count;
   logic        short_pkt;
   state_t      dbg_state;

   always #5 clk = ~clk;

   axis_packetizer_if #(.DATA_W(W)) s_if ();
   axis_packetizer_if #(.DATA_W(W)) m_if ();

   axis_packetizer #(
      .C_S_AXIS_TDATA_WIDTH (W),
      .C_M_AXIS_TDATA_WIDTH (W),
      .PKT_WORDS            (PKT),
      .TIMEOUT_CYCLES       (TMO)
   ) dut (
      .AXIS_ACLK    (clk),
      .AXIS_ARESETN (rst_n),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .pkt_count    (pkt_count),
      .short_pkt    (short_pkt),
      .o_dbg_state  (dbg_state)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [W:0]  exp_q[$];
   logic        exp_short_q[$];
   logic [15:0] exp_cnt_q[$];
   logic [15:0] exp_pkts = 16'd0;
   int          ready_mode = 0;
   int          ready_idx = 0;
   logic        manual_ready = 1'b0;
   int          tlast_cyc = -1;
   int          first_acc_cyc = 0;
   int          hs_count = 0;
   logic [W-1:0] pkt_data[PKT];
   int          pkt_gap[PKT];

   logic        prev_stall = 1'b0;
   logic [W:0]  prev_beat = '0;
   logic        chk_pending = 1'b0;
   logic        exp_short_hold = 1'b0;
   logic [15:0] exp_cnt_hold = 16'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Downstream ready generator: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never, 4 manual.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: m_if.tready = 1'b1;
         1: begin
            m_if.tready = ((ready_idx % 4) == 0) || ((ready_idx % 4) == 3);
            ready_idx++;
         end
         2: m_if.tready = 1'($urandom_range(0, 1));
         3: m_if.tready = 1'b0;
         default: m_if.tready = manual_ready;
      endcase
   end

   // Monitor: compares every output handshake against the expected queue.
   always @(negedge clk) begin
      logic [W:0] beat;
      if (!rst_n) begin
         prev_stall  = 1'b0;
         chk_pending = 1'b0;
      end else begin
         if (chk_pending) begin
            check("short_pkt_pulse", 64'(short_pkt), 64'(exp_short_hold));
            check("pkt_count", 64'(pkt_count), 64'(exp_cnt_hold));
            chk_pending = 1'b0;
         end else begin
            check("short_pkt_idle", 64'(short_pkt), 64'd0);
         end
         if (prev_stall)
            check("stall_hold", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, prev_beat}));
         if (m_if.tvalid) begin
            check("s_tready_in_send", 64'(s_if.tready), 64'd0);
            check("dbg_state_send", 64'(dbg_state), 64'(SEND));
            if (m_if.tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got 0x%0h with nothing expected", m_if.tdata);
               end else begin
                  beat = exp_q.pop_front();
                  check("beat", 64'({m_if.tlast, m_if.tdata}), 64'(beat));
                  hs_count++;
                  if (beat[W] && exp_short_q.size() != 0) begin
                     exp_short_hold = exp_short_q.pop_front();
                     exp_cnt_hold   = exp_cnt_q.pop_front();
                     chk_pending    = 1'b1;
                     tlast_cyc      = cyc;
                  end
               end
            end
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_beat  = {m_if.tlast, m_if.tdata};
      end
   end

   task automatic send_word(input logic [W-1:0] d, input logic last, output int acc_cyc);
      int   budget;
      logic rdy;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = last;
      s_if.tstrb  = 4'($urandom);
      budget = 0;
      rdy    = 1'b0;
      acc_cyc = 0;
      while (!rdy && budget < 3000) begin
         @(negedge clk);
         rdy     = s_if.tready;
         acc_cyc = cyc;
         budget++;
         @(posedge clk);
      end
      #1;
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL input_accept_timeout: word 0x%0h never accepted", d);
      end
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   // Model: a packet is the word list; padding fills zeros up to PKT beats.
   task automatic drive_pkt(input int n, input logic use_tlast);
      int beats;
      int acc;
      exp_pkts = exp_pkts + 16'd1;
      beats = n;
`ifdef AXIS_PKT_PAD_EN
      beats = PKT;
`endif
      for (int i = 0; i < beats; i++)
         exp_q.push_back({(i == beats - 1), (i < n) ? pkt_data[i] : W'(0)});
      exp_short_q.push_back(n != PKT);
      exp_cnt_q.push_back(exp_pkts);
      for (int i = 0; i < n; i++) begin
         repeat (pkt_gap[i]) begin
            @(posedge clk);
            #1;
         end
         send_word(pkt_data[i], use_tlast && (i == n - 1), acc);
         if (i == 0) first_acc_cyc = acc;
      end
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || chk_pending) && budget < 6000) begin
         @(negedge clk);
         budget++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic measure_latency(output int n);
      n = 0;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         if (m_if.tvalid) break;
      end
   endtask

   task automatic set_pkt(input int n, input logic [W-1:0] base);
      for (int i = 0; i < PKT; i++) begin
         pkt_data[i] = base + W'(i);
         pkt_gap[i]  = 0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hs_base;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_s_tready", 64'(s_if.tready), 64'd0);
      check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
      check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
      check("rst_pkt_count", 64'(pkt_count), 64'd0);
      check("rst_short_pkt", 64'(short_pkt), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(FILL));
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_tready", 64'(s_if.tready), 64'd1);
      @(posedge clk);
      #1;

      // Full packet 0x1..0x8, first valid the cycle after the 8th accept
      ready_mode = 0;
      set_pkt(PKT, 32'h1);
      drive_pkt(PKT, 1'b0);
      measure_latency(lat);
      check("full_latency", 64'(lat), 64'd1);
      wait_drain();

      // Timeout flush of 3 words
      set_pkt(3, 32'hA);
      drive_pkt(3, 1'b0);
      measure_latency(lat);
      check("timeout_latency", 64'(lat), 64'(TMO + 1));
      wait_drain();

      // Early TLAST on the 5th word
      set_pkt(5, 32'h50);
      drive_pkt(5, 1'b1);
      measure_latency(lat);
      check("tlast_latency", 64'(lat), 64'd1);
      wait_drain();

      // Accept lands exactly on the timeout-expiry cycle
      set_pkt(3, 32'h300);
      pkt_gap[1] = TMO - 1;
      drive_pkt(3, 1'b1);
      measure_latency(lat);
      check("expiry_accept_latency", 64'(lat), 64'd1);
      wait_drain();

      // Backpressure 1,0,0,1
      ready_mode = 1;
      ready_idx  = 0;
      set_pkt(PKT, 32'h1);
      drive_pkt(PKT, 1'b0);
      wait_drain();

      // Input held during SEND: accepted the cycle after the TLAST handshake
      ready_mode = 2;
      set_pkt(PKT, 32'h100);
      drive_pkt(PKT, 1'b0);
      set_pkt(PKT, 32'h200);
      drive_pkt(PKT, 1'b0);
      check("held_word_accept_cycle", 64'(first_acc_cyc), 64'(tlast_cyc + 1));
      wait_drain();

      // Reset after beat 3 of 8
      manual_ready = 1'b0;
      ready_mode   = 4;
      @(posedge clk);
      #1;
      set_pkt(PKT, 32'h400);
      drive_pkt(PKT, 1'b0);
      hs_base = hs_count;
      @(negedge clk);
      manual_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      manual_ready = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      exp_short_q.delete();
      exp_cnt_q.delete();
      exp_pkts = 16'd0;
      #1;
      check("mid_send_beats_before_reset", 64'(hs_count - hs_base), 64'd3);
      check("mid_send_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      check("mid_send_rst_m_tlast", 64'(m_if.tlast), 64'd0);
      check("mid_send_rst_pkt_count", 64'(pkt_count), 64'd0);
      check("mid_send_rst_s_tready", 64'(s_if.tready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 0;
      @(posedge clk);
      #1;
      set_pkt(PKT, 32'h500);
      drive_pkt(PKT, 1'b0);
      wait_drain();

      // Randomized packets of random length, framing and backpressure
      for (int p = 0; p < 40; p++) begin
         int   n;
         logic tl;
         n  = $urandom_range(1, PKT);
         tl = 1'($urandom_range(0, 1));
         ready_mode = $urandom_range(0, 2);
         for (int i = 0; i < PKT; i++) begin
            pkt_data[i] = $urandom;
            pkt_gap[i]  = (i == 0) ? 0 : $urandom_range(0, 3);
         end
         drive_pkt(n, tl);
         if (n < PKT && !tl) wait_drain();
      end
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
